// File: rtl/gray_codec_pkg.sv
// gray_codec_pkg: mode encodings, Gray->binary chunk sizing and the pipeline stage record shared by gray_codec_pipe
package gray_codec_pkg;
  localparam int MAX_WIDTH = 64;
  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;
  typedef struct packed {
    logic                 valid;
    logic                 mode;
    logic [MAX_WIDTH-1:0] data;
  } stage_t;
  function automatic int chunk_size(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction
endpackage

// File: rtl/gray_codec_stage.sv
// gray_codec_stage: enabled register stage (clk, sync active-low rst, en, in_s -> out_s) resolving Gray->binary bits HI..LO; the FIRST stage also does binary->Gray
module gray_codec_stage
  import gray_codec_pkg::*;
#(
  parameter int   WIDTH = 4,
  parameter int   LO    = 0,
  parameter int   HI    = WIDTH - 1,
  parameter logic FIRST = 1'b0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  stage_t in_s,
  output stage_t out_s
);
  stage_t s_d, s_q;
  always_comb begin
    s_d = in_s;
    if (FIRST && in_s.mode == MODE_B2G)
      s_d.data = in_s.data ^ (in_s.data >> 1);
    else if (in_s.mode == MODE_G2B)
      for (int i = WIDTH - 2; i >= 0; i--)
        if (i >= LO && i <= HI) s_d.data[i] = s_d.data[i+1] ^ in_s.data[i];
  end
  always_ff @(posedge clk)
    if (!rst) s_q <= '0;
    else if (en) s_q <= s_d;
  assign out_s = s_q;
endmodule

// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe: valid/ready pipelined Gray codec (in_valid/in_ready/in_mode/in_data -> out_valid/out_ready/out_mode/out_data, mode 0 = b->g, 1 = g->b), latency STAGES, sync active-low rst
module gray_codec_pipe
  import gray_codec_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data
);
  localparam int C = chunk_size(WIDTH, STAGES);
  stage_t p [STAGES+1];
  logic   en;
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign p[0]      = '{valid: in_valid, mode: in_mode, data: MAX_WIDTH'(in_data)};
  assign out_valid = p[STAGES].valid;
  assign out_mode  = p[STAGES].mode;
  assign out_data  = p[STAGES].data[WIDTH-1:0];
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int HI = WIDTH - 1 - k * C;
    localparam int LO = (WIDTH - (k + 1) * C > 0) ? WIDTH - (k + 1) * C : 0;
    gray_codec_stage #(
      .WIDTH(WIDTH),
      .LO   (LO),
      .HI   (HI),
      .FIRST(k == 0)
    ) u_stage (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .in_s (p[k]),
      .out_s(p[k+1])
    );
  end
  if (WIDTH < MAX_WIDTH) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^p[STAGES].data[MAX_WIDTH-1:WIDTH];
  end
endmodule

// File: tb/tb_gray_codec_pipe.sv
// tb_gray_codec_pipe: randomized and directed checks of gray_codec_pipe against an arithmetic Gray model
module tb_gray_codec_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int n_pass = 0;
  int n_total = 0;

  logic       a_iv, a_ir, a_im, a_ov, a_or, a_om;
  logic [3:0] a_id, a_od;
  gray_codec_pipe #(.WIDTH(4), .STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_mode(a_im), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_mode(a_om), .out_data(a_od)
  );

  logic       b_iv, b_ir, b_im, b_ov, b_or, b_om;
  logic [7:0] b_id, b_od;
  gray_codec_pipe #(.WIDTH(8), .STAGES(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_mode(b_im), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_mode(b_om), .out_data(b_od)
  );

  logic       c_iv, c_im;
  logic [5:0] c_id [3];
  logic [5:0] c_od [3];
  logic       c_ir [3];
  logic       c_ov [3];
  logic       c_om [3];
  for (genvar g = 0; g < 3; g++) begin : g_rt
    gray_codec_pipe #(.WIDTH(6), .STAGES(g == 0 ? 1 : (g == 1 ? 3 : 6))) dut_c (
      .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir[g]), .in_mode(c_im), .in_data(c_id[g]),
      .out_valid(c_ov[g]), .out_ready(1'b1), .out_mode(c_om[g]), .out_data(c_od[g])
    );
  end

  function automatic logic [63:0] to_gray(input logic [63:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [63:0] to_bin(input logic [63:0] g);
    logic [63:0] r = '0;
    for (int s = 0; s < 64; s++) r ^= g >> s;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick;
    tick;
    n_total++; if (a_ov !== 1'b0) $display("FAIL reset_a_out_valid got %b want 0", a_ov); else n_pass++;
    n_total++; if (a_od !== 4'h0) $display("FAIL reset_a_out_data got %h want 0", a_od); else n_pass++;
    n_total++; if (a_om !== 1'b0) $display("FAIL reset_a_out_mode got %b want 0", a_om); else n_pass++;
    n_total++; if (a_ir !== 1'b1) $display("FAIL reset_a_in_ready got %b want 1", a_ir); else n_pass++;
    n_total++; if (b_ov !== 1'b0 || b_od !== 8'h00) $display("FAIL reset_b_out got v=%b d=%h want v=0 d=00", b_ov, b_od); else n_pass++;
    for (int g = 0; g < 3; g++) begin
      n_total++; if (c_ov[g] !== 1'b0) $display("FAIL reset_c%0d_out_valid got %b want 0", g, c_ov[g]); else n_pass++;
    end
    rst = 1'b1;
  endtask

  task automatic test_basic;
    a_or = 1'b1; a_iv = 1'b1; a_im = 1'b0; a_id = 4'b1011;
    tick;
    a_iv = 1'b0;
    n_total++; if (a_ov !== 1'b0) $display("FAIL basic_early got out_valid=%b want 0", a_ov); else n_pass++;
    tick;
    n_total++; if (a_ov !== 1'b1) $display("FAIL basic_valid got %b want 1", a_ov); else n_pass++;
    n_total++; if (a_om !== 1'b0) $display("FAIL basic_mode got %b want 0", a_om); else n_pass++;
    n_total++; if (a_od !== 4'b1110) $display("FAIL basic_data got %b want 1110", a_od); else n_pass++;
    tick;
    n_total++; if (a_ov !== 1'b0) $display("FAIL basic_drain got out_valid=%b want 0", a_ov); else n_pass++;
  endtask

  task automatic test_back_to_back;
    b_or = 1'b1; b_iv = 1'b1; b_im = 1'b1; b_id = 8'h80;
    tick;
    b_im = 1'b0; b_id = 8'hFF;
    tick;
    b_iv = 1'b0;
    n_total++; if (b_ov !== 1'b0) $display("FAIL b2b_early got out_valid=%b want 0", b_ov); else n_pass++;
    tick;
    n_total++; if ({b_ov, b_om, b_od} !== {1'b1, 1'b1, 8'hFF}) $display("FAIL b2b_first got v=%b m=%b d=%h want v=1 m=1 d=ff", b_ov, b_om, b_od); else n_pass++;
    tick;
    n_total++; if ({b_ov, b_om, b_od} !== {1'b1, 1'b0, 8'h80}) $display("FAIL b2b_second got v=%b m=%b d=%h want v=1 m=0 d=80", b_ov, b_om, b_od); else n_pass++;
    tick;
    n_total++; if (b_ov !== 1'b0) $display("FAIL b2b_drain got out_valid=%b want 0", b_ov); else n_pass++;
  endtask

  task automatic test_backpressure;
    int idx = 0;
    int cyc = 0;
    logic [3:0] got [$];
    logic prev_stall = 1'b0;
    logic [3:0] prev_od = '0;
    a_im = 1'b0;
    while (got.size() < 8 && cyc < 100) begin
      a_or = (cyc % 4 == 0) || (cyc % 4 == 3);
      a_iv = idx < 8;
      a_id = 4'(idx);
      @(negedge clk);
      if (a_ov) begin
        n_total++; if (a_ir !== a_or) $display("FAIL bp_in_ready cyc %0d got %b want %b", cyc, a_ir, a_or); else n_pass++;
      end
      if (prev_stall) begin
        n_total++; if (a_ov !== 1'b1 || a_od !== prev_od) $display("FAIL bp_stable cyc %0d got v=%b d=%h want v=1 d=%h", cyc, a_ov, a_od, prev_od); else n_pass++;
      end
      prev_stall = a_ov && !a_or;
      prev_od = a_od;
      if (a_ov && a_or) got.push_back(a_od);
      if (a_iv && a_ir) idx++;
      cyc++;
      tick;
    end
    n_total++; if (got.size() != 8) $display("FAIL bp_count got %0d want 8", got.size()); else n_pass++;
    for (int i = 0; i < got.size(); i++) begin
      n_total++; if (got[i] !== 4'(to_gray(64'(i)))) $display("FAIL bp_order idx %0d got %h want %h", i, got[i], 4'(to_gray(64'(i)))); else n_pass++;
    end
    a_iv = 1'b0; a_or = 1'b1;
    repeat (4) tick;
  endtask

  task automatic test_bubbles;
    logic p [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] d [4];
    logic m [4];
    logic exp_v;
    logic [3:0] exp_d;
    a_or = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        a_iv = p[c]; a_id = 4'($urandom); a_im = 1'($urandom);
        d[c] = a_id; m[c] = a_im;
      end else a_iv = 1'b0;
      @(negedge clk);
      exp_v = (c >= 2 && c < 6) ? p[c-2] : 1'b0;
      n_total++; if (a_ov !== exp_v) $display("FAIL bubble_valid cyc %0d got %b want %b", c, a_ov, exp_v); else n_pass++;
      if (exp_v) begin
        exp_d = m[c-2] ? 4'(to_bin(64'(d[c-2]))) : 4'(to_gray(64'(d[c-2])));
        n_total++; if (a_od !== exp_d || a_om !== m[c-2]) $display("FAIL bubble_data cyc %0d got m=%b d=%h want m=%b d=%h", c, a_om, a_od, m[c-2], exp_d); else n_pass++;
      end
      tick;
    end
  endtask

  task automatic test_random;
    logic [8:0] q [$];
    logic [8:0] w;
    logic [7:0] exp_d;
    logic hold = 1'b0;
    logic acc;
    int n = 0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        b_iv = $urandom_range(0, 3) != 0; b_im = 1'($urandom); b_id = 8'($urandom);
      end
      b_or = $urandom_range(0, 3) != 0;
      @(negedge clk);
      acc = b_iv && b_ir;
      if (b_ov && b_or) begin
        n_total++;
        if (q.size() == 0) $display("FAIL rand_spurious cyc %0d got d=%h with nothing expected", c, b_od);
        else begin
          w = q.pop_front();
          exp_d = w[8] ? 8'(to_bin(64'(w[7:0]))) : 8'(to_gray(64'(w[7:0])));
          if (b_om !== w[8] || b_od !== exp_d) $display("FAIL rand_data cyc %0d got m=%b d=%h want m=%b d=%h", c, b_om, b_od, w[8], exp_d);
          else n_pass++;
        end
      end
      if (acc) q.push_back({b_im, b_id});
      hold = b_iv && !acc;
      tick;
    end
    b_iv = 1'b0; b_or = 1'b1;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      if (b_ov) begin
        w = q.pop_front();
        exp_d = w[8] ? 8'(to_bin(64'(w[7:0]))) : 8'(to_gray(64'(w[7:0])));
        n_total++; if (b_om !== w[8] || b_od !== exp_d) $display("FAIL rand_drain got m=%b d=%h want m=%b d=%h", b_om, b_od, w[8], exp_d); else n_pass++;
      end
      n++;
      tick;
    end
    n_total++; if (q.size() != 0) $display("FAIL rand_lost got %0d words outstanding want 0", q.size()); else n_pass++;
    @(negedge clk);
    n_total++; if (b_ov !== 1'b0) $display("FAIL rand_extra got out_valid=%b want 0", b_ov); else n_pass++;
    tick;
  endtask

  task automatic test_round_trip;
    logic [5:0] res [3][64];
    logic [5:0] fin [3][64];
    int cnt [3];
    for (int ph = 0; ph < 2; ph++) begin
      cnt = '{0, 0, 0};
      for (int c = 0; c < 74; c++) begin
        c_iv = c < 64;
        c_im = ph == 1;
        for (int g = 0; g < 3; g++) c_id[g] = (c >= 64) ? 6'd0 : (ph == 0 ? 6'(c) : res[g][c]);
        @(negedge clk);
        for (int g = 0; g < 3; g++)
          if (c_ov[g] && cnt[g] < 64) begin
            if (ph == 0) res[g][cnt[g]] = c_od[g];
            else fin[g][cnt[g]] = c_od[g];
            cnt[g]++;
          end
        tick;
      end
      for (int g = 0; g < 3; g++) begin
        n_total++; if (cnt[g] != 64) $display("FAIL rt_count dut %0d phase %0d got %0d want 64", g, ph, cnt[g]); else n_pass++;
      end
    end
    c_iv = 1'b0;
    for (int g = 0; g < 3; g++)
      for (int v = 0; v < 64; v++) begin
        n_total++; if (fin[g][v] !== 6'(v)) $display("FAIL rt_value dut %0d got %h want %h", g, fin[g][v], 6'(v)); else n_pass++;
      end
  endtask

  task automatic test_reset_midstream;
    a_or = 1'b0; a_iv = 1'b1; a_im = 1'b0; a_id = 4'h5;
    tick;
    a_im = 1'b1; a_id = 4'hA;
    tick;
    a_iv = 1'b0;
    n_total++; if (a_ov !== 1'b1 || a_ir !== 1'b0) $display("FAIL mid_loaded got v=%b rdy=%b want v=1 rdy=0", a_ov, a_ir); else n_pass++;
    rst = 1'b0;
    tick;
    rst = 1'b1; a_or = 1'b1;
    n_total++; if (a_ov !== 1'b0) $display("FAIL mid_out_valid got %b want 0", a_ov); else n_pass++;
    n_total++; if (a_od !== 4'h0 || a_om !== 1'b0) $display("FAIL mid_out_data got m=%b d=%h want m=0 d=0", a_om, a_od); else n_pass++;
    n_total++; if (a_ir !== 1'b1) $display("FAIL mid_in_ready got %b want 1", a_ir); else n_pass++;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_total++; if (a_ov !== 1'b0) $display("FAIL mid_stale cyc %0d got out_valid=%b want 0", c, a_ov); else n_pass++;
      tick;
    end
    a_iv = 1'b1; a_im = 1'b1; a_id = 4'hC;
    tick;
    a_iv = 1'b0;
    n_total++; if (a_ov !== 1'b0) $display("FAIL mid_latency_early got out_valid=%b want 0", a_ov); else n_pass++;
    tick;
    n_total++; if ({a_ov, a_om, a_od} !== {1'b1, 1'b1, 4'(to_bin(64'h0C))}) $display("FAIL mid_first_word got v=%b m=%b d=%h want v=1 m=1 d=%h", a_ov, a_om, a_od, 4'(to_bin(64'h0C))); else n_pass++;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    a_iv = 1'b0; a_im = 1'b0; a_id = '0; a_or = 1'b1;
    b_iv = 1'b0; b_im = 1'b0; b_id = '0; b_or = 1'b1;
    c_iv = 1'b0; c_im = 1'b0;
    for (int g = 0; g < 3; g++) c_id[g] = '0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_backpressure;
    test_bubbles;
    test_random;
    test_round_trip;
    test_reset_midstream;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/gray_codec_pipe.md
Name: gray_codec_pipe

Overview:
Parametrised, pipelined bidirectional Gray codec. Each transfer selects its own mode: binary->Gray or Gray->binary. Gray->binary is a serial prefix-XOR, so it is split across STAGES register stages to meet timing at large WIDTH. Uses a valid/ready stream interface with full backpressure. Serves as the general-purpose successor to the fixed 4-bit converter, e.g. for CDC pointer encode/decode.

Parameters:
WIDTH, 4, data width in bits; legal range 2..64.
STAGES, 2, pipeline depth and latency in cycles; legal range 1..WIDTH.

Ports:
clk  in  1  system clock; all logic rising-edge.
rst  in  1  synchronous reset, active-low.
in_valid  in  1  input word present.
in_ready  out  1  block accepts input this cycle.
in_mode  in  1  0 = binary->Gray, 1 = Gray->binary.
in_data  in  WIDTH  word to convert.
out_valid  out  1  result present.
out_ready  in  1  downstream accepts result.
out_mode  out  1  mode that produced out_data.
out_data  out  WIDTH  converted word.

Behaviour:
- Reset: rst sampled low at a rising clk edge clears all stage valids, data and mode registers to 0. After that edge, out_valid=0, out_data=0, out_mode=0 and in_ready=1. Reset during operation discards all in-flight words; none are emitted.
- Transfer: an input is accepted when in_valid && in_ready. An output is consumed when out_valid && out_ready.
- Global enable: en = !out_valid || out_ready; in_ready = en.
  - When en=1, every stage advances by one.
  - When en=0, every stage holds, and out_data/out_mode stay stable.
  - Bubbles are not compressed. Pipeline occupancy is at most STAGES words.
- Latency: exactly STAGES enabled cycles from acceptance to out_valid. A word accepted at edge N appears after edge N+STAGES-1 when no stall occurs.
- Throughput: one word per cycle while out_ready=1. Accept and emit in the same cycle are legal.
- Binary->Gray: g = b ^ (b >> 1). Fully computed in stage 0; stages 1..STAGES-1 pass the word through unchanged.
- Gray->binary: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i].
  - Chunk C = ceil(WIDTH/STAGES).
  - Stage k resolves bits WIDTH-1-k*C down to max(0, WIDTH-(k+1)*C), using the resolved bit above the chunk carried from stage k-1.
  - Unresolved low bits travel as raw Gray bits.
  - Stages with an empty chunk pass the word through.
- Mode travels with its word; mixed-mode back-to-back streams are legal.
- No arithmetic overflow is possible; all operations are bitwise on WIDTH bits.
- in_valid=1 with in_ready=0: the input is not captured. The source holds the word (AXI-stream style); the block does not check this.
- in_data/in_mode are don't-care while in_valid=0. Bubble stages keep valid=0.

Decomposition:
- Package gray_codec_pkg: MODE_B2G=1'b0, MODE_G2B=1'b1; function chunk_size(WIDTH, STAGES); stage-register struct {valid, mode, data}.
- Sub-module gray_codec_stage, parameters WIDTH, LO, HI. One register stage with enable, synchronous active-low reset and partial prefix-XOR over bits HI..LO. Instantiated STAGES times in a generate loop. Stage 0 also applies the b^(b>>1) transform for MODE_B2G.

Test Plan:
- WIDTH=4, STAGES=2, out_ready=1: in_mode=0, in_data=4'b1011 -> after 2 cycles out_valid=1, out_mode=0, out_data=4'b1110.
- WIDTH=8, STAGES=3: in_mode=1, in_data=8'h80 -> out_data=8'hFF. in_mode=0, in_data=8'hFF -> out_data=8'h80. Issue both back-to-back; outputs appear on consecutive cycles in order.
- Backpressure, WIDTH=4, STAGES=2: stream 0..7 with out_ready toggling 1,0,0,1,...
  - in_ready equals out_ready whenever out_valid=1.
  - out_data stays stable while stalled.
  - No loss or duplication: the output sequence equals Gray(0..7) = 0,1,3,2,6,7,5,4.
- Exhaustive round trip, WIDTH=6, STAGES in {1,3,6}: every value v is sent as B2G, its result is fed back as G2B, and the final output equals v for all 64 values.
- Reset mid-stream: rst=0 for 1 cycle with 2 words in flight -> next cycle out_valid=0, out_data=0, in_ready=1. No stale word appears afterwards. The first word after reset emerges with latency STAGES.
- Bubbles: in_valid pattern 1,0,1,0 with out_ready=1 -> out_valid pattern 1,0,1,0 delayed by STAGES cycles, with correct data.
